pipe_stage_chain: RTL
=====================

# pipe_stage_chain

Parametrised elastic pipeline register chain. It replaces the fixed, always-advancing inter-stage registers between datapath stages with DEPTH valid-tagged stages. Stages use a valid/ready handshake, bubble collapsing, synchronous flush, and an occupancy count. It sits between any two datapath stages and carries a packed bundle of the downstream stage's data and control fields.

## Interface
- WORD_LENGTH, 32, width of the packed payload (data plus control bits) carried per beat.
- DEPTH, 4, number of register stages; legal range 1..16.
- CNT_LENGTH, $clog2(DEPTH+2), width of `count`; derived, not overridden.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets).
- flush  in  1  synchronous flush; discards all held and incoming beats.
- in_valid  in  1  upstream offers `in_data`.
- in_ready  out  1  chain accepts a beat this cycle.
- in_data  in  WORD_LENGTH  upstream payload.
- out_valid  out  1  stage DEPTH-1 holds a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  WORD_LENGTH  payload of stage DEPTH-1.
- count  out  CNT_LENGTH  registered number of valid beats held, including the skid entry.

## Operation
- State per stage i (0..DEPTH-1): `v[i]` and `d[i]`. Stage DEPTH-1 drives `out_valid` and `out_data`.
- Per-stage ready: `r[DEPTH] = out_ready`; `r[i] = !v[i] || r[i+1]`. Stage i loads from stage i-1, or from the input when i==0, when `r[i]` is 1.
  - On load, `v[i]` takes the source's valid bit; a load from an invalid source clears `v[i]`.
- Bubble collapsing: an invalid stage always accepts, so gaps close while the output is stalled.
- Transfers: input transfer = `in_valid && in_ready`; output transfer = `out_valid && out_ready`.
- Order is strictly FIFO. Beats are never duplicated or dropped except by flush or reset.
- Data registers update only on load. Payload held in invalid stages is don't-care for checking, but resets to 0.
- `count` next = count + in_xfer − out_xfer. `count` is 0 after a flush.
- Flush: all `v[i]` and the skid valid clear at the edge. An input beat offered in the flush cycle is discarded. An output transfer in the flush cycle still counts as consumed.
- Priority: rst > flush > normal operation.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, all v=0. `in_ready`=1 in the first cycle after reset.
- Latency: a beat accepted in cycle c is presented on `out_*` in cycle c+DEPTH, assuming no stalls. Throughput is 1 beat/cycle under `out_ready`=1.
- Without the skid, `in_ready` is combinational from `out_ready` through the ready chain.
- `out_valid` and `out_data` come directly from registers; there is no combinational path from input to output.
- Full: DEPTH beats held (DEPTH+1 with skid) and `out_ready`=0, so `in_ready`=0. If `out_ready`=1 while full, a simultaneous in/out transfer is permitted and `count` is unchanged.
- Empty: `out_valid`=0; `out_ready` is ignored.
- Reset mid-stream: all held beats are lost at the edge. There is no output transfer in the reset cycle.
- DEPTH=1: a single valid-tagged register; `in_ready = !v[0] || out_ready`.

## Configuration
- `PIPE_SKID_EN` defined: a one-entry skid buffer is placed before stage 0, and `in_ready = !skid_valid` is a registered output.
  - An input beat goes to stage 0 if `r[0]` is 1, otherwise to the skid.
  - Stage 0 loads from the skid whenever the skid is valid.
  - Latency is unchanged while the skid is empty. Capacity is DEPTH+1.
- Undefined: no skid; combinational `in_ready`; capacity DEPTH.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 and in_data=0xAA. Required after release: out_valid=0, count=0, in_ready=1, and 0xAA never appears on the output.
- Streaming, DEPTH=4, out_ready=1: push 0x11..0x18 in consecutive cycles starting at cycle 0. Required: out_valid=1 with 0x11..0x18 in cycles 4..11, no gaps, count steady at 4.
- Backpressure: out_ready=0, push continuously. Required: in_ready falls after 4 accepts (5 with `PIPE_SKID_EN`) and count saturates at 4 (5). Then set out_ready=1: all beats drain in order and count reaches 0.
- Bubble collapse: out_ready=0; push 0x01, idle 2 cycles, push 0x02. Required: count=2. After release, 0x01 and 0x02 appear in consecutive cycles.
- Flush: with 3 beats held and in_valid=1 carrying 0x55, pulse flush for 1 cycle. Required: next cycle out_valid=0 and count=0, and 0x55 never appears on the output.
- Reset mid-stream: drop rst for 1 cycle while streaming. Required: out_valid=0 and count=0 next cycle, and streaming resumes cleanly with the correct latency.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Elastic register chain of DEPTH valid-tagged stages that sits between two
// datapath stages. Each stage accepts a beat whenever it is empty or its
// successor is accepting, so bubbles collapse while the output is stalled and
// a full chain streams at one beat per cycle. Beats leave in strict FIFO order.
// A registered occupancy count tracks the number of beats held.
//
// Optional feature (compile-time macro PIPE_SKID_EN):
//   defined   : a one-entry skid buffer sits in front of stage 0, in_ready is
//               a registered output (!skid_valid), and capacity is DEPTH+1.
//   undefined : no skid, in_ready is combinational through the ready chain,
//               and capacity is DEPTH.
//
// Parameters:
//   WORD_LENGTH  payload width per beat
//   DEPTH        number of register stages (1..16)
//   CNT_LENGTH   width of count, derived from DEPTH
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   flush      synchronous flush; drops held beats and the incoming beat
//   in_valid   upstream offers in_data
//   in_ready   chain accepts a beat this cycle
//   in_data    upstream payload
//   out_valid  last stage holds a valid beat (registered)
//   out_ready  downstream consumes the beat this cycle
//   out_data   payload of the last stage (registered)
//   count      registered number of valid beats held (skid included)
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter  int WORD_LENGTH = 32,
  parameter  int DEPTH       = 4,
  localparam int CNT_LENGTH  = $clog2(DEPTH + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic [CNT_LENGTH-1:0]  count
);

  logic [DEPTH-1:0]       r_v;
  logic [WORD_LENGTH-1:0] r_d [DEPTH];
  logic [CNT_LENGTH-1:0]  r_count;

  logic [DEPTH-1:0]       w_rdy;
  logic                   w_src_v;
  logic [WORD_LENGTH-1:0] w_src_d;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  // Stage i is ready when any stage from i to the end is empty, or the
  // downstream consumer is ready. Written in closed form so the ready bits do
  // not feed back into each other.
  // NOTE: every output of an always_comb gets a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!r_v[j]) w_rdy[i] = 1'b1;
      end
    end
  end

`ifdef PIPE_SKID_EN
  logic                   r_skid_v;
  logic [WORD_LENGTH-1:0] r_skid_d;

  // A held skid beat always has priority into stage 0; while it is held the
  // input is closed, so there is never a competing input beat.
  assign in_ready  = !r_skid_v;
  assign w_src_v   = r_skid_v ? 1'b1     : in_valid;
  assign w_src_d   = r_skid_v ? r_skid_d : in_data;
  assign w_in_xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (flush) begin
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      // Skid drains into stage 0 as soon as stage 0 accepts.
      r_skid_v <= !w_rdy[0];
    end else if (w_in_xfer && !w_rdy[0]) begin
      // Stage 0 is blocked: park the accepted beat.
      r_skid_v <= 1'b1;
      r_skid_d <= in_data;
    end
  end
`else
  assign in_ready  = w_rdy[0];
  assign w_src_v   = in_valid;
  assign w_src_d   = in_data;
  assign w_in_xfer = in_valid && in_ready;
`endif

  assign w_out_xfer = r_v[DEPTH-1] && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would let a beat
  // ripple through several stages in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v     <= '0;
      r_count <= '0;
      // NOTE: payload registers are cleared on reset so out_data reads 0 after
      // reset; this is a small register chain, not a RAM, so the reset is cheap.
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else if (flush) begin
      // Valid tags and count clear; payload is left as don't-care.
      r_v     <= '0;
      r_count <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= w_src_v;
        r_d[0] <= w_src_d;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
      r_count <= r_count + CNT_LENGTH'(w_in_xfer) - CNT_LENGTH'(w_out_xfer);
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

endmodule
